// File: rtl/icache_dataram_arbiter_pkg.sv
// Shared widths and the linefill write-buffer entry type for the icache data-array arbiter.
package icache_dataram_arbiter_pkg;

    localparam int ICACHE_INDEX_WIDTH     = 6;
    localparam int ICACHE_DATA_WIDTH      = 64;
    localparam int ICACHE_REQ_TXNID_WIDTH = 4;
    localparam int MSHR_ENTRY_INDEX_WIDTH = 2;

    // Array address key is {index, way}; way is the LSB.
    localparam int ICACHE_ARR_ADDR_WIDTH  = ICACHE_INDEX_WIDTH + 1;

    typedef struct packed {
        logic [ICACHE_INDEX_WIDTH-1:0]     index;
        logic                              way;
        logic [ICACHE_DATA_WIDTH-1:0]      data;
        logic [ICACHE_REQ_TXNID_WIDTH-1:0] txnid;
        logic [MSHR_ENTRY_INDEX_WIDTH-1:0] entry_idx;
    } icache_lf_wr_entry_t;

    function automatic logic [ICACHE_ARR_ADDR_WIDTH-1:0] arr_key(
        input logic [ICACHE_INDEX_WIDTH-1:0] index,
        input logic                          way
    );
        return {index, way};
    endfunction

endpackage

// File: rtl/icache_dataram_arbiter_if.sv
// Bus bundle between hit pipeline / linefill RX, the arbiter and the data array.
// Handshakes: a transfer happens at a posedge where vld && rdy; vld never waits on rdy,
// while rd_rdy may depend combinationally on rd_vld/rd_index/rd_way (hazard compare).
interface icache_dataram_arbiter_if
    import icache_dataram_arbiter_pkg::*;
#(
    parameter int LF_DEPTH = 2
);
    localparam int CNT_W = $clog2(LF_DEPTH + 1);

    logic                              rd_vld;
    logic                              rd_rdy;
    logic                              rd_way;
    logic [ICACHE_INDEX_WIDTH-1:0]     rd_index;
    logic [ICACHE_REQ_TXNID_WIDTH-1:0] rd_txnid;

    logic                              lf_vld;
    logic                              lf_rdy;
    logic                              lf_way;
    logic [ICACHE_INDEX_WIDTH-1:0]     lf_index;
    logic [ICACHE_DATA_WIDTH-1:0]      lf_data;
    logic [ICACHE_REQ_TXNID_WIDTH-1:0] lf_txnid;
    logic [MSHR_ENTRY_INDEX_WIDTH-1:0] lf_entry_idx;

    logic                              arr_en;
    logic                              arr_wr_en;
    logic [ICACHE_ARR_ADDR_WIDTH-1:0]  arr_addr;
    logic [ICACHE_DATA_WIDTH-1:0]      arr_wdata;

    logic                              rd_rsp_vld;
    logic [ICACHE_REQ_TXNID_WIDTH-1:0] rd_rsp_txnid;

    logic                              lf_ack_vld;
    logic [MSHR_ENTRY_INDEX_WIDTH-1:0] lf_ack_entry_idx;
    logic [ICACHE_REQ_TXNID_WIDTH-1:0] lf_ack_txnid;

    logic [CNT_W-1:0]                  lf_cnt;

    modport master (
        output rd_vld, rd_way, rd_index, rd_txnid,
        output lf_vld, lf_way, lf_index, lf_data, lf_txnid, lf_entry_idx,
        input  rd_rdy, lf_rdy, arr_en, arr_wr_en, arr_addr, arr_wdata,
        input  rd_rsp_vld, rd_rsp_txnid, lf_ack_vld, lf_ack_entry_idx, lf_ack_txnid, lf_cnt
    );

    modport slave (
        input  rd_vld, rd_way, rd_index, rd_txnid,
        input  lf_vld, lf_way, lf_index, lf_data, lf_txnid, lf_entry_idx,
        output rd_rdy, lf_rdy, arr_en, arr_wr_en, arr_addr, arr_wdata,
        output rd_rsp_vld, rd_rsp_txnid, lf_ack_vld, lf_ack_entry_idx, lf_ack_txnid, lf_cnt
    );

endinterface

// File: rtl/icache_lf_wr_buf.sv
// In-order linefill write buffer; exposes per-slot valid and {index, way} for hazard checks.
module icache_lf_wr_buf
    import icache_dataram_arbiter_pkg::*;
#(
    parameter  int DEPTH = 2,
    localparam int CNT_W = $clog2(DEPTH + 1),
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                                        clk,
    input  logic                                        rst_n,
    input  logic                                        push_i,
    input  icache_lf_wr_entry_t                         push_entry_i,
    input  logic                                        pop_i,
    output icache_lf_wr_entry_t                         head_o,
    output logic [CNT_W-1:0]                            cnt_o,
    output logic [DEPTH-1:0]                            ent_vld_o,
    output logic [DEPTH-1:0][ICACHE_ARR_ADDR_WIDTH-1:0] ent_key_o
);

    icache_lf_wr_entry_t mem_q [DEPTH];
    logic [DEPTH-1:0]    vld_q;
    logic [PTR_W-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]    cnt_q;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk) begin
        if (push_i) begin
            mem_q[wr_ptr_q] <= push_entry_i;
        end
    end

    // Push and pop never address the same slot: that would need the buffer both empty and full.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (push_i) begin
                vld_q[wr_ptr_q] <= 1'b1;
                wr_ptr_q        <= ptr_inc(wr_ptr_q);
            end
            if (pop_i) begin
                vld_q[rd_ptr_q] <= 1'b0;
                rd_ptr_q        <= ptr_inc(rd_ptr_q);
            end
            case ({push_i, pop_i})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            ent_key_o[i] = arr_key(mem_q[i].index, mem_q[i].way);
        end
    end

    assign head_o    = mem_q[rd_ptr_q];
    assign cnt_o     = cnt_q;
    assign ent_vld_o = vld_q;

endmodule

// File: rtl/icache_dataram_arbiter.sv
// Single-port icache data array arbiter: reads win unless a buffered linefill write is forced out.
module icache_dataram_arbiter
    import icache_dataram_arbiter_pkg::*;
#(
    parameter int LF_DEPTH    = 2,
    parameter int WR_MAX_WAIT = 4
) (
    input logic                     clk,
    input logic                     rst_n,
    icache_dataram_arbiter_if.slave bus
);

    localparam int CNT_W  = $clog2(LF_DEPTH + 1);
    localparam int WAIT_W = $clog2(WR_MAX_WAIT + 1);

    icache_lf_wr_entry_t                                push_entry;
    icache_lf_wr_entry_t                                head;
    logic [CNT_W-1:0]                                   cnt;
    logic [LF_DEPTH-1:0]                                ent_vld;
    logic [LF_DEPTH-1:0][ICACHE_ARR_ADDR_WIDTH-1:0]     ent_key;
    logic [ICACHE_ARR_ADDR_WIDTH-1:0]                   rd_key;
    logic                                               hazard;
    logic                                               buf_nonempty;
    logic                                               force_wr;
    logic                                               rd_rdy;
    logic                                               lf_push;
    logic                                               wr_sel;
    logic                                               rd_sel;
    logic [WAIT_W-1:0]                                  wait_q, wait_d;
    logic                                               rsp_vld_q;
    logic [ICACHE_REQ_TXNID_WIDTH-1:0]                  rsp_txnid_q;

    assign push_entry = '{index:     bus.lf_index,
                          way:       bus.lf_way,
                          data:      bus.lf_data,
                          txnid:     bus.lf_txnid,
                          entry_idx: bus.lf_entry_idx};

    assign bus.lf_rdy = rst_n && (cnt < CNT_W'(LF_DEPTH));
    assign lf_push    = bus.lf_vld && bus.lf_rdy;

    icache_lf_wr_buf #(.DEPTH(LF_DEPTH)) u_lf_wr_buf (
        .clk          (clk),
        .rst_n        (rst_n),
        .push_i       (lf_push),
        .push_entry_i (push_entry),
        .pop_i        (wr_sel),
        .head_o       (head),
        .cnt_o        (cnt),
        .ent_vld_o    (ent_vld),
        .ent_key_o    (ent_key)
    );

    // Only already-stored entries count: a line accepted this cycle is ordered after the read.
    assign rd_key = arr_key(bus.rd_index, bus.rd_way);
    always_comb begin
        hazard = 1'b0;
        for (int i = 0; i < LF_DEPTH; i++) begin
            if (ent_vld[i] && (ent_key[i] == rd_key)) hazard = 1'b1;
        end
        hazard = hazard && bus.rd_vld;
    end

    assign buf_nonempty = (cnt != '0);
    assign force_wr     = (cnt == CNT_W'(LF_DEPTH)) || (wait_q == WAIT_W'(WR_MAX_WAIT)) || hazard;
    assign rd_rdy       = rst_n && !(buf_nonempty && force_wr);
    assign wr_sel       = rst_n && buf_nonempty && (!bus.rd_vld || !rd_rdy);
    assign rd_sel       = bus.rd_vld && rd_rdy;

    always_comb begin
        wait_d = wait_q;
        if (wr_sel || !buf_nonempty) begin
            wait_d = '0;
        end else if (wait_q != WAIT_W'(WR_MAX_WAIT)) begin
            wait_d = wait_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wait_q      <= '0;
            rsp_vld_q   <= 1'b0;
            rsp_txnid_q <= '0;
        end else begin
            wait_q    <= wait_d;
            rsp_vld_q <= rd_sel;
            if (rd_sel) rsp_txnid_q <= bus.rd_txnid;
        end
    end

    assign bus.rd_rdy           = rd_rdy;
    assign bus.arr_en           = rd_sel || wr_sel;
    assign bus.arr_wr_en        = wr_sel;
    assign bus.arr_addr         = wr_sel ? arr_key(head.index, head.way) : rd_key;
    assign bus.arr_wdata        = wr_sel ? head.data : '0;
    assign bus.rd_rsp_vld       = rsp_vld_q;
    assign bus.rd_rsp_txnid     = rsp_txnid_q;
    assign bus.lf_ack_vld       = wr_sel;
    assign bus.lf_ack_entry_idx = wr_sel ? head.entry_idx : '0;
    assign bus.lf_ack_txnid     = wr_sel ? head.txnid : '0;
    assign bus.lf_cnt           = cnt;

endmodule

// File: tb/tb_icache_dataram_arbiter.sv
// Bench for icache_dataram_arbiter: directed scenarios plus random traffic against a queue-based model.
module tb_icache_dataram_arbiter;
    import icache_dataram_arbiter_pkg::*;

    localparam int LF_DEPTH    = 2;
    localparam int WR_MAX_WAIT = 4;
    localparam int IW = ICACHE_INDEX_WIDTH;
    localparam int DW = ICACHE_DATA_WIDTH;
    localparam int TW = ICACHE_REQ_TXNID_WIDTH;
    localparam int EW = MSHR_ENTRY_INDEX_WIDTH;
    localparam int AW = ICACHE_ARR_ADDR_WIDTH;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_err;

    icache_dataram_arbiter_if #(.LF_DEPTH(LF_DEPTH)) bus ();

    icache_dataram_arbiter #(
        .LF_DEPTH    (LF_DEPTH),
        .WR_MAX_WAIT (WR_MAX_WAIT)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- model state ----------------
    icache_lf_wr_entry_t   mdl_q[$];
    logic [TW+EW-1:0]      exp_q[$];
    int                    mdl_wait;
    bit                    mdl_rsp_vld;
    logic [TW-1:0]         mdl_rsp_txnid;
    bit                    mdl_after_rst;
    logic [DW-1:0]         mdl_mem [2**AW];
    logic [DW-1:0]         tb_arr  [2**AW];

    task automatic check_eq(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // ---------------- driver + model step ----------------
    task automatic drive_cycle(input logic rst, input logic rv, input logic rw,
                               input logic [IW-1:0] ri, input logic [TW-1:0] rt,
                               input logic lv, input logic lw,
                               input logic [IW-1:0] li, input logic [EW-1:0] le);
        int                  cnt;
        bit                  haz, full, starving, e_rd_rdy, e_lf_rdy, e_wr, e_rd;
        logic [AW-1:0]       rd_addr;
        logic [AW-1:0]       e_addr;
        logic [DW-1:0]       e_wdata;
        icache_lf_wr_entry_t h, n;
        logic [TW+EW-1:0]    a;

        @(negedge clk);
        rst_n            = rst;
        bus.rd_vld       = rv;
        bus.rd_way       = rw;
        bus.rd_index     = ri;
        bus.rd_txnid     = rt;
        bus.lf_vld       = lv;
        bus.lf_way       = lw;
        bus.lf_index     = li;
        bus.lf_data      = {$urandom(), $urandom()};
        bus.lf_txnid     = TW'($urandom_range(0, 2**TW - 1));
        bus.lf_entry_idx = le;
        #1;

        // A write is due when the buffer holds something and either no read wants
        // the array, or the buffer is full, the head has waited its limit, or the
        // read targets a line still sitting in the buffer.
        cnt      = mdl_q.size();
        rd_addr  = {ri, rw};
        haz      = 1'b0;
        foreach (mdl_q[i]) if ({mdl_q[i].index, mdl_q[i].way} == rd_addr) haz = 1'b1;
        haz      = haz && rv;
        full     = (cnt == LF_DEPTH);
        starving = (mdl_wait >= WR_MAX_WAIT);
        e_rd_rdy = rst && !(cnt > 0 && (full || starving || haz));
        e_wr     = rst && cnt > 0 && (!rv || full || starving || haz);
        e_rd     = rst && rv && !e_wr;
        e_lf_rdy = rst && (cnt < LF_DEPTH);
        e_addr   = e_wr ? {mdl_q[0].index, mdl_q[0].way} : rd_addr;
        e_wdata  = e_wr ? mdl_q[0].data : '0;

        check_eq("rd_rdy",     bus.rd_rdy,     e_rd_rdy);
        check_eq("lf_rdy",     bus.lf_rdy,     e_lf_rdy);
        check_eq("arr_en",     bus.arr_en,     e_wr || e_rd);
        check_eq("arr_wr_en",  bus.arr_wr_en,  e_wr);
        check_eq("arr_addr",   bus.arr_addr,   e_addr);
        check_eq("arr_wdata",  bus.arr_wdata,  e_wdata);
        check_eq("lf_ack_vld", bus.lf_ack_vld, e_wr);
        check_eq("lf_cnt",     bus.lf_cnt,     cnt);
        check_eq("rsp_vld",    bus.rd_rsp_vld, mdl_rsp_vld);
        if (mdl_rsp_vld) check_eq("rsp_txnid", bus.rd_rsp_txnid, mdl_rsp_txnid);
        if (mdl_after_rst) check_eq("rsp_txnid_rst", bus.rd_rsp_txnid, '0);
        if (e_wr) begin
            check_eq("ack_entry", bus.lf_ack_entry_idx, mdl_q[0].entry_idx);
            check_eq("ack_txnid", bus.lf_ack_txnid,     mdl_q[0].txnid);
        end
        if (e_rd) check_eq("rd_data", tb_arr[rd_addr], mdl_mem[rd_addr]);

        // Scoreboard: every ack must match the oldest outstanding accepted linefill.
        if (bus.lf_ack_vld === 1'b1) begin
            if (exp_q.size() == 0) begin
                check_eq("ack_unexpected", 1, 0);
            end else begin
                a = exp_q.pop_front();
                check_eq("ack_order", {bus.lf_ack_txnid, bus.lf_ack_entry_idx}, a);
            end
        end

        // The array itself, as the DUT drives it.
        if (bus.arr_en === 1'b1 && bus.arr_wr_en === 1'b1) tb_arr[bus.arr_addr] = bus.arr_wdata;

        mdl_after_rst = !rst;
        if (!rst) begin
            mdl_q.delete();
            exp_q.delete();
            mdl_wait      = 0;
            mdl_rsp_vld   = 1'b0;
            mdl_rsp_txnid = '0;
        end else begin
            if (e_wr) begin
                h = mdl_q.pop_front();
                mdl_mem[{h.index, h.way}] = h.data;
            end
            if (lv && e_lf_rdy) begin
                n = '{index: li, way: lw, data: bus.lf_data, txnid: bus.lf_txnid, entry_idx: le};
                mdl_q.push_back(n);
                exp_q.push_back({bus.lf_txnid, le});
            end
            if (e_wr || cnt == 0) mdl_wait = 0;
            else if (mdl_wait < WR_MAX_WAIT) mdl_wait++;
            mdl_rsp_vld = e_rd;
            if (e_rd) mdl_rsp_txnid = rt;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive_cycle(1, 0, 0, '0, '0, 0, 0, '0, '0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        n_cmp = 0;
        n_err = 0;
        mdl_wait = 0;
        mdl_rsp_vld = 1'b0;
        mdl_rsp_txnid = '0;
        mdl_after_rst = 1'b0;
        for (int i = 0; i < 2**AW; i++) begin
            mdl_mem[i] = '0;
            tb_arr[i]  = '0;
        end
        rst_n = 1'b0;
        bus.rd_vld = 0; bus.rd_way = 0; bus.rd_index = '0; bus.rd_txnid = '0;
        bus.lf_vld = 0; bus.lf_way = 0; bus.lf_index = '0; bus.lf_data = '0;
        bus.lf_txnid = '0; bus.lf_entry_idx = '0;
        repeat (2) @(posedge clk);
        drive_cycle(0, 0, 0, '0, '0, 0, 0, '0, '0);

        // Idle read: index 5 way 1 txnid 3.
        drive_cycle(1, 1, 1, 6'd5, 4'd3, 0, 0, '0, '0);
        idle(1);

        // Idle linefill: index 9 way 0 entry 2.
        drive_cycle(1, 0, 0, '0, '0, 1, 0, 6'd9, 2'd2);
        idle(2);

        // Starvation under continuous reads.
        drive_cycle(1, 1, 0, 6'd1, 4'd1, 1, 1, 6'd20, 2'd1);
        for (int i = 0; i < 7; i++) drive_cycle(1, 1, 0, 6'd1, TW'(i), 0, 0, '0, '0);
        idle(1);

        // Full buffer under continuous reads.
        drive_cycle(1, 1, 1, 6'd2, 4'd4, 1, 0, 6'd30, 2'd0);
        drive_cycle(1, 1, 1, 6'd2, 4'd5, 1, 1, 6'd31, 2'd1);
        for (int i = 0; i < 8; i++) drive_cycle(1, 1, 1, 6'd2, TW'(i), 0, 0, '0, '0);
        idle(2);

        // Read-after-write hazard on index 7 way 0.
        drive_cycle(1, 1, 0, 6'd3, 4'd6, 1, 0, 6'd7, 2'd3);
        drive_cycle(1, 1, 0, 6'd7, 4'd7, 0, 0, '0, '0);
        drive_cycle(1, 1, 0, 6'd7, 4'd7, 0, 0, '0, '0);
        idle(1);

        // Reset while two lines are buffered.
        drive_cycle(1, 1, 0, 6'd4, 4'd8, 1, 0, 6'd40, 2'd0);
        drive_cycle(1, 1, 0, 6'd4, 4'd9, 1, 1, 6'd41, 2'd1);
        drive_cycle(0, 1, 0, 6'd4, 4'd10, 1, 0, 6'd42, 2'd2);
        drive_cycle(1, 1, 1, 6'd5, 4'd11, 0, 0, '0, '0);
        idle(2);

        // Random traffic on a small address set so hazards are frequent.
        for (int i = 0; i < 1500; i++) begin
            drive_cycle(($urandom_range(0, 99) != 0),
                        ($urandom_range(0, 9) < 7),
                        1'($urandom_range(0, 1)),
                        IW'($urandom_range(0, 3)),
                        TW'($urandom_range(0, 2**TW - 1)),
                        ($urandom_range(0, 9) < 4),
                        1'($urandom_range(0, 1)),
                        IW'($urandom_range(0, 3)),
                        EW'($urandom_range(0, 2**EW - 1)));
        end
        idle(8);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/icache_dataram_arbiter.md
# icache_dataram_arbiter

Sequences the single-port icache data array between latency-critical hit reads and linefill writes returning from downstream. Linefill beats are accepted into a small write buffer instead of stalling reads every cycle. Reads win by default; buffered writes are forced out on buffer-full, starvation timeout or read-after-write address hazard. Sits between the hit pipeline / downstream RX channel and the two half-line data array memories.

## Interface
- INDEX_WIDTH, ICACHE_INDEX_WIDTH, set index width
- DATA_WIDTH, ICACHE_DATA_WIDTH, full cacheline width
- TXNID_WIDTH, ICACHE_REQ_TXNID_WIDTH, upstream transaction id width
- ENTRY_IDX_WIDTH, MSHR_ENTRY_INDEX_WIDTH, MSHR entry index width
- LF_DEPTH, 2, linefill write buffer entries (≥1)
- WR_MAX_WAIT, 4, max cycles a buffered write may be bypassed by reads (≥1)

- clk  in  1  clock; single clock domain
- rst_n  in  1  reset; synchronous, active-low
- rd_vld / rd_rdy  in / out  1 / 1  hit read request handshake
- rd_way, rd_index, rd_txnid  in  1, INDEX_WIDTH, TXNID_WIDTH  read target and id
- lf_vld / lf_rdy  in / out  1 / 1  linefill write handshake
- lf_way, lf_index  in  1, INDEX_WIDTH  resolved destination (from MSHR)
- lf_data, lf_txnid, lf_entry_idx  in  DATA_WIDTH, TXNID_WIDTH, ENTRY_IDX_WIDTH  line, id, MSHR entry
- arr_en, arr_wr_en  out  1, 1  array enable; 1 = write, 0 = read
- arr_addr  out  INDEX_WIDTH+1  {index, way}
- arr_wdata  out  DATA_WIDTH  write line (caller splits halves)
- rd_rsp_vld, rd_rsp_txnid  out  1, TXNID_WIDTH  aligned with array read data
- lf_ack_vld, lf_ack_entry_idx, lf_ack_txnid  out  1, ENTRY_IDX_WIDTH, TXNID_WIDTH  write issued to array
- lf_cnt  out  $clog2(LF_DEPTH+1)  buffer occupancy

## Operation
- Buffer: in-order FIFO of {index, way, data, txnid, entry_idx}. Enqueue on lf_vld && lf_rdy. lf_rdy = rst_n && (lf_cnt < LF_DEPTH). No pass-through: an entry is first eligible the cycle after acceptance.
- hazard = rd_vld && a stored valid entry has {index, way} == {rd_index, rd_way}. An entry being accepted this cycle is excluded; the read ordered before it sees old data.
- force_wr = lf_cnt==LF_DEPTH || wait_cnt==WR_MAX_WAIT || hazard.
- rd_rdy = rst_n && !(lf_cnt>0 && force_wr).
- wr_sel = rst_n && lf_cnt>0 && (!rd_vld || !rd_rdy): head is written, popped and acked the same cycle.
- rd_sel = rd_vld && rd_rdy. rd_sel and wr_sel are mutually exclusive.
- arr_en = rd_sel || wr_sel; arr_wr_en = wr_sel. arr_addr and arr_wdata come from the head on wr_sel, otherwise from rd_*. arr_wdata = 0 when not writing.
- wait_cnt counts cycles with lf_cnt>0 && !wr_sel and saturates at WR_MAX_WAIT. It clears on wr_sel or when lf_cnt==0.
- Hazard with multiple matches: writes drain in order until no match remains. The read then issues.
- Simultaneous enqueue and dequeue: lf_cnt unchanged. Pointers wrap modulo LF_DEPTH.

## Timing
- Read: grant is combinational in the request cycle. rd_rsp_vld/rd_rsp_txnid are registered, one cycle later, matching the memory's 1-cycle read latency.
- Linefill: minimum 1 cycle from accept to array write. Worst case under continuous reads is 1+WR_MAX_WAIT cycles for the head entry.
- lf_ack_* is combinational, asserted in the cycle arr_wr_en is high.
- rd_rdy depends combinationally on rd_vld/rd_index/rd_way through the hazard compare.
- Reset values (rst_n low at edge): lf_cnt=0, pointers=0, wait_cnt=0, rd_rsp_vld=0, rd_rsp_txnid=0.
- While rst_n is low: rd_rdy=lf_rdy=arr_en=lf_ack_vld=0.
- Reset mid-operation discards buffered lines; no ack is ever issued for them. Any read issued in the reset cycle's previous cycle still returns rd_rsp_vld only if reset is not asserted at that edge.

## Structure
- Add icache_lf_wr_entry_t {index, way, data, txnid, entry_idx} to toy_pack.
- One natural sub-module: icache_lf_wr_buf. It holds the FIFO storage, pointers and count, and exposes per-entry valid and {index, way} for the hazard compare.
- Arbitration, wait counter and response register stay in the top.

## Test plan
- Idle read: rd index 5, way 1, txnid 3 → same cycle arr_en=1, arr_wr_en=0, arr_addr={5,1}; next cycle rd_rsp_vld=1, txnid 3.
- Idle linefill: accept index 9, way 0, entry 2 at cycle 0 → cycle 1 arr_wr_en=1, addr={9,0}, lf_ack_entry_idx=2; lf_cnt goes 1→0.
- Starvation, WR_MAX_WAIT=4: continuous reads, one linefill accepted at cycle 0 → reads granted cycles 1–4. Cycle 5: rd_rdy=0 and the write issues. Cycle 6: reads resume.
- Full buffer, LF_DEPTH=2: continuous reads, linefills at cycles 0 and 1 → lf_cnt=2 and lf_rdy=0 at cycle 2. The forced write occurs at cycle 2 and lf_rdy=1 at cycle 3.
- Hazard: buffer holds index 7, way 0; read index 7, way 0 → rd_rdy=0 until that write issues. The read grants the next cycle and returns the newly written line.
- Reset mid-operation: lf_cnt=2, rst_n low one cycle → lf_cnt=0, no lf_ack_vld, rd_rsp_vld=0; subsequent reads work normally.
